// File: rtl/prog_clk_divider.sv
// Purpose: runtime-programmable clock divider / tick generator (toggle, pulse, fractional).
// Latency: s_clk and tick are registered; they change on the clk edge that sees the terminal event.
// Backpressure: none; en freezes counting, load is a fire-and-forget strobe reported via pending.
module prog_clk_divider #(
    parameter int WIDTH       = 12,
    parameter int DEFAULT_DIV = 2267,
    parameter int FRAC_WIDTH  = 24,
    parameter int DEFAULT_INC = 14797
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic                  load,
    input  logic [WIDTH-1:0]      div_in,
    input  logic [FRAC_WIDTH-1:0] inc_in,
    output logic                  s_clk,
    output logic                  tick,
    output logic                  pending
);

    localparam logic [1:0] MODE_PULSE = 2'b01;
    localparam logic [1:0] MODE_FRAC  = 2'b10;

    localparam logic [WIDTH-1:0]      DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [FRAC_WIDTH-1:0] INC_RST = FRAC_WIDTH'(DEFAULT_INC);

    logic [WIDTH-1:0]      cuenta;
    logic [WIDTH-1:0]      div_reg;
    logic [WIDTH-1:0]      shadow_div;
    logic [FRAC_WIDTH-1:0] acc;
    logic [FRAC_WIDTH-1:0] inc_reg;
    logic [FRAC_WIDTH-1:0] shadow_inc;
    logic [1:0]            mode_q;

    logic [FRAC_WIDTH:0]   acc_sum;
    logic                  frac_mode;
    logic                  mode_change;
    logic                  term;
    logic                  apply;

    // Terminal event and reload decision for this edge; mode 11 falls through to toggle behaviour.
    always_comb begin
        acc_sum     = {1'b0, acc} + {1'b0, inc_reg};
        frac_mode   = (mode == MODE_FRAC);
        mode_change = (mode != mode_q);
        term        = 1'b0;
        if (en) begin
            term = frac_mode ? acc_sum[FRAC_WIDTH] : (cuenta == div_reg);
        end
        // A load on this edge supersedes the old shadow, so nothing is applied then.
        // While disabled there is no period in progress to protect, so apply at once.
        apply = pending && !load && !mode_change && (term || !en);
    end

    // Period counter (integer modes) and phase accumulator (fractional mode).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cuenta <= '0;
            acc    <= '0;
        end else if (mode_change) begin
            cuenta <= '0;
            acc    <= '0;
        end else if (en) begin
            if (frac_mode) begin
                acc <= acc_sum[FRAC_WIDTH-1:0];
            end else if (term) begin
                cuenta <= '0;
            end else begin
                cuenta <= cuenta + 1'b1;
            end
        end
    end

    // Output strobes: tick marks every terminal event, s_clk toggles or mirrors tick in pulse mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_clk <= 1'b0;
            tick  <= 1'b0;
        end else if (mode_change) begin
            s_clk <= 1'b0;
            tick  <= 1'b0;
        end else begin
            tick <= term;
            // In pulse mode s_clk is a registered copy of tick, so it also drops while disabled.
            if (mode == MODE_PULSE) begin
                s_clk <= term;
            end else if (term) begin
                s_clk <= ~s_clk;
            end
        end
    end

    // Shadow capture and period-boundary reload of divisor and increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q     <= 2'b00;
            div_reg    <= DIV_RST;
            inc_reg    <= INC_RST;
            shadow_div <= DIV_RST;
            shadow_inc <= INC_RST;
            pending    <= 1'b0;
        end else begin
            mode_q <= mode;
            if (load) begin
                shadow_div <= div_in;
                shadow_inc <= inc_in;
                pending    <= 1'b1;
            end else if (apply) begin
                div_reg <= shadow_div;
                inc_reg <= shadow_inc;
                pending <= 1'b0;
            end
        end
    end

endmodule
